conv_mac_array: RTL

- Parametrised successor to the single-accumulator custom-0 convolution unit.
- Sits in the issue slot of the biriscv pipeline and receives the same opcode bundle.
- Holds NUM_ACC independent signed fixed-point accumulators (synthesizable, no floating point) and supports scalar MAC plus packed 4-lane int8 dot-product MAC.
- Provides a multi-cycle multiplier pipeline, saturating accumulation, and a shifted, clamped readback.

---
 rtl/conv_pkg.sv | 64 ++++++
 rtl/conv_mul_pipe.sv | 55 +++++
 rtl/conv_mac_array.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the conv_mac_array unit.
// Contents:
//   OPC_CUSTOM0          - custom-0 major opcode
//   F3_*                 - funct3 operation encodings
//   conv_state_t         - control FSM states
//   sat_add(a, b, width) - signed add, clamped to a width-bit range; returns {sat, sum}
//   clamp32(v)           - clamp a signed 64-bit value to the int32 range
package conv_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [2:0] F3_CLR    = 3'b000;
  localparam logic [2:0] F3_MAC    = 3'b001;
  localparam logic [2:0] F3_RD     = 3'b010;
  localparam logic [2:0] F3_DOT4   = 3'b011;
  localparam logic [2:0] F3_CLRALL = 3'b100;

  localparam logic signed [63:0] I32_MAX = 64'sd2147483647;
  localparam logic signed [63:0] I32_MIN = -64'sd2147483648;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } conv_state_t;

  // 65-bit intermediate keeps the true sum exact; width must be 2..64.
  function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int unsigned        width);
    logic signed [64:0] s;
    logic signed [64:0] maxv;
    logic signed [64:0] minv;
    logic               sat;
    logic [63:0]        r;
    s    = $signed({a[63], a}) + $signed({b[63], b});
    maxv = (65'sd1 <<< (width - 1)) - 65'sd1;
    minv = -(65'sd1 <<< (width - 1));
    sat  = 1'b0;
    r    = s[63:0];
    if (s > maxv) begin
      sat = 1'b1;
      r   = maxv[63:0];
    end else if (s < minv) begin
      sat = 1'b1;
      r   = minv[63:0];
    end
    return {sat, r};
  endfunction

  function automatic logic [31:0] clamp32(input logic signed [63:0] v);
    logic [31:0] r;
    if (v > I32_MAX) begin
      r = 32'h7FFF_FFFF;
    end else if (v < I32_MIN) begin
      r = 32'h8000_0000;
    end else begin
      r = v[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_mul_pipe.sv
// MUL_STAGES-deep registered multiplier: scalar signed 32x32 product or
// packed 4-lane int8 dot-product sum, chosen by mode_i.
// Ports:
//   clk_i, rst_ni - clock, async active-low reset
//   mode_i        - 0: scalar product, 1: DOT4 sum
//   a_i, b_i      - operands
//   p_o           - signed 64-bit result, MUL_STAGES cycles after inputs
module conv_mul_pipe #(
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mode_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] p_o
);

  logic signed [63:0] stage_q [MUL_STAGES];
  logic signed [63:0] stage_d;
  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic signed [17:0] dot;
  logic signed [17:0] la;
  logic signed [17:0] lb;

  // First stage: both products formed, one selected.
  always_comb begin
    sa  = 64'($signed(a_i));
    sb  = 64'($signed(b_i));
    dot = '0;
    la  = '0;
    lb  = '0;
    for (int i = 0; i < 4; i++) begin
      la  = 18'($signed(a_i[8*i +: 8]));
      lb  = 18'($signed(b_i[8*i +: 8]));
      dot = dot + la * lb;
    end
    stage_d = mode_i ? 64'(dot) : sa * sb;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q[0] <= stage_d;
      for (int i = 1; i < int'(MUL_STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign p_o = stage_q[MUL_STAGES-1];

endmodule

// File: rtl/conv_mac_array.sv
// Custom-0 multi-accumulator MAC unit: scalar MAC, 4-lane int8 DOT4 MAC,
// saturating accumulation and shifted/clamped int32 readback.
// Ports:
//   clk_i, rst_ni     - clock, async active-low reset
//   opcode_*_i        - issue bundle (pc and register indices unused)
//   busy_o            - unit occupied (MUL/ACC)
//   valid_o           - one-cycle completion pulse
//   writeback_o       - result, held between completions
//   sat_o             - OR of sticky per-accumulator saturation flags
module conv_mac_array
  import conv_pkg::*;
#(
  parameter int unsigned NUM_ACC    = 4,
  parameter int unsigned ACC_W      = 48,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned RD_SHIFT   = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [31:0] opcode_pc_i,
  input  logic        opcode_invalid_i,
  input  logic [4:0]  opcode_rd_idx_i,
  input  logic [4:0]  opcode_ra_idx_i,
  input  logic [4:0]  opcode_rb_idx_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] writeback_o,
  output logic        sat_o
);

  localparam int unsigned SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int unsigned CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  conv_state_t              state_q, state_d;
  logic [2:0]               op_q, op_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [31:0]              ra_q, ra_d;
  logic [31:0]              rb_q, rb_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q [NUM_ACC];
  logic signed [ACC_W-1:0]  acc_d [NUM_ACC];
  logic [NUM_ACC-1:0]       sat_q, sat_d;
  logic                     busy_q, busy_d;
  logic                     valid_q, valid_d;
  logic [31:0]              wb_q, wb_d;
  logic                     sat_any_q, sat_any_d;

  logic                     accept;
  logic [2:0]               funct3;
  logic [63:0]              mul_p;
  logic [64:0]              sa;
  logic [31:0]              result;
  logic                     dot_mode;

  function automatic logic [31:0] readback(input logic signed [ACC_W-1:0] a);
    logic signed [63:0] w;
    w = 64'(a);
    w = w >>> RD_SHIFT;
    return clamp32(w);
  endfunction

  assign funct3   = opcode_opcode_i[14:12];
  assign accept   = (state_q == ST_IDLE) && opcode_valid_i && !opcode_invalid_i &&
                    (opcode_opcode_i[6:0] == OPC_CUSTOM0);
  assign dot_mode = (op_q == F3_DOT4);

  conv_mul_pipe #(
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .mode_i (dot_mode),
    .a_i    (ra_q),
    .b_i    (rb_q),
    .p_o    (mul_p)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    wb_d    = wb_q;
    sa      = '0;
    result  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = funct3;
          sel_d = (NUM_ACC > 1) ? opcode_opcode_i[25 +: SEL_W] : '0;
          ra_d  = opcode_ra_operand_i;
          rb_d  = opcode_rb_operand_i;
          cnt_d = CNT_W'(MUL_STAGES - 1);
          state_d = (funct3 == F3_MAC || funct3 == F3_DOT4) ? ST_MUL : ST_ACC;
        end
      end
      ST_MUL: begin
        // Counter covers exactly MUL_STAGES cycles so the pipe output is ready in ACC.
        if (cnt_q == '0) begin
          state_d = ST_ACC;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACC: begin
        unique case (op_q)
          F3_CLR: begin
            acc_d[sel_q] = '0;
            sat_d[sel_q] = 1'b0;
          end
          F3_MAC, F3_DOT4: begin
            sa           = sat_add(64'(acc_q[sel_q]), mul_p, ACC_W);
            acc_d[sel_q] = sa[ACC_W-1:0];
            if (sa[64]) begin
              sat_d[sel_q] = 1'b1;
            end
            result = readback(sa[ACC_W-1:0]);
          end
          F3_RD: begin
            result = readback(acc_q[sel_q]);
          end
          F3_CLRALL: begin
            acc_d = '{default: '0};
            sat_d = '0;
          end
          default: begin
          end
        endcase
        wb_d    = result;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d    = (state_d == ST_MUL) || (state_d == ST_ACC);
    valid_d   = (state_d == ST_DONE);
    sat_any_d = |sat_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      sel_q     <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '{default: '0};
      sat_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      wb_q      <= '0;
      sat_any_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      wb_q      <= wb_d;
      sat_any_q <= sat_any_d;
    end
  end

  assign busy_o      = busy_q;
  assign valid_o     = valid_q;
  assign writeback_o = wb_q;
  assign sat_o       = sat_any_q;

  // Bundle fields kept only for pipeline compatibility.
  logic unused_ok;
  assign unused_ok = ^{opcode_pc_i, opcode_rd_idx_i, opcode_ra_idx_i, opcode_rb_idx_i,
                       opcode_opcode_i, sa};

endmodule
